// File: rtl/obi_pkg.sv
// OBI request/response types shared by the banked SRAM path, plus the
// per-transaction tracking entry used by the bank demux.
package obi_pkg;

  // Widest bank index a demux entry can carry (up to 16 banks).
  localparam int SEL_W = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             err;
  } bank_demux_entry_t;

endpackage

// File: rtl/obi_resp_fifo.sv
// In-order tracking FIFO of outstanding demux transactions; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module obi_resp_fifo
  import obi_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  bank_demux_entry_t din,
  output bank_demux_entry_t head,
  output logic              full,
  output logic              empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  bank_demux_entry_t mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= nxt(wptr);
      end
      if (do_pop) rptr <= nxt(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/obi_bank_demux.sv
// Address-decodes one OBI master onto NUM_BANKS bank ports and returns
// responses in issue order; bad addresses and gated banks are answered locally.
module obi_bank_demux
  import obi_pkg::*;
#(
  parameter int NUM_BANKS       = 2,
  parameter int BANK_ADDR_WIDTH = 15,
  parameter int INTERLEAVED     = 0,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  obi_req_t                  master_req_i,
  output obi_resp_t                 master_resp_o,
  output logic                      master_err_o,
  output obi_req_t  [NUM_BANKS-1:0] bank_req_o,
  input  obi_resp_t [NUM_BANKS-1:0] bank_resp_i,
  input  logic      [NUM_BANKS-1:0] bank_off_i,
  output logic                      protocol_err_o
);

  localparam int B  = $clog2(NUM_BANKS);
  localparam int HI = BANK_ADDR_WIDTH + B;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [B-1:0]      sel, hsel;
  logic [31:0]       bank_addr, rsp_data;
  logic              req_err, gnt, pop, rsp_valid, rsp_err, stray;
  logic              full, empty, first_after_rst, err_pending;
  logic [CW-1:0]     err_cnt;
  logic [NUM_BANKS-1:0] bank_gnt;
  bank_demux_entry_t entry, head;
  logic              unused;

  always_comb begin
    if (INTERLEAVED != 0) begin
      sel       = master_req_i.addr[2 +: B];
      bank_addr = ((master_req_i.addr >> (2 + B)) << 2) | {30'd0, master_req_i.addr[1:0]};
    end else begin
      sel       = master_req_i.addr[BANK_ADDR_WIDTH +: B];
      bank_addr = master_req_i.addr;
    end
  end

  assign req_err = (|(master_req_i.addr >> HI)) || bank_off_i[sel];
  assign gnt     = master_req_i.req && !rst_i && (!full || pop);
  assign entry   = '{sel: SEL_W'(sel), err: req_err};
  assign hsel    = head.sel[B-1:0];

  obi_resp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (gnt),
    .pop   (pop),
    .din   (entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_req_o[b] = '0;
      bank_gnt[b]   = bank_resp_i[b].gnt;
      if (gnt && !req_err && sel == B'(b)) begin
        bank_req_o[b]      = master_req_i;
        bank_req_o[b].addr = bank_addr;
      end
    end
  end

  // Errored entries answer on their own as soon as they reach the head.
  assign err_pending = (err_cnt != '0);

  always_comb begin
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    stray     = 1'b0;
    if (!empty && head.err) begin
      rsp_valid = err_pending;
      rsp_err   = err_pending;
    end else if (!empty) begin
      rsp_valid = bank_resp_i[hsel].rvalid;
      rsp_data  = bank_resp_i[hsel].rdata;
    end
    for (int b = 0; b < NUM_BANKS; b++)
      if (bank_resp_i[b].rvalid && (empty || head.err || hsel != B'(b))) stray = 1'b1;
  end

  assign pop = rsp_valid && !rst_i;

  always_comb begin
    master_resp_o.gnt    = gnt;
    master_resp_o.rvalid = pop;
    master_resp_o.rdata  = rst_i ? '0 : rsp_data;
    master_err_o         = rsp_err && !rst_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt         <= '0;
      protocol_err_o  <= 1'b0;
      first_after_rst <= 1'b1;
    end else begin
      first_after_rst <= 1'b0;
      err_cnt         <= err_cnt + CW'(gnt && req_err) - CW'(pop && rsp_err);
      // Responses still draining from before reset are not protocol errors.
      if (stray && !first_after_rst) protocol_err_o <= 1'b1;
    end
  end

  assign unused = ^{bank_gnt, head.sel};

endmodule

// File: tb/tb_obi_bank_demux.sv
// Bench for obi_bank_demux: contiguous and interleaved instances, table-driven
// requests with a response scoreboard, plus reset and protocol-error sequences.
module tb_obi_bank_demux;
  import obi_pkg::*;

  localparam int NB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  obi_req_t           mreq  [2];
  obi_resp_t          mresp [2];
  logic               merr  [2];
  logic               perr  [2];
  obi_req_t  [NB-1:0] breq  [2];
  obi_resp_t [NB-1:0] bresp [2];
  logic      [NB-1:0] boff  [2];
  logic      [NB-1:0] inj   [2];
  logic      [NB-1:0] brv   [2];
  logic      [31:0]   brd   [2][NB];
  logic      [31:0]   bmem  [logic [63:0]];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } sb_t;
  sb_t q0[$], q1[$];

  typedef struct {
    int          d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  off;
    logic        err;
    int          bank;
    logic [31:0] baddr;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl[$];

  obi_bank_demux #(.NUM_BANKS(NB), .BANK_ADDR_WIDTH(15), .INTERLEAVED(0), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst), .master_req_i(mreq[0]), .master_resp_o(mresp[0]),
    .master_err_o(merr[0]), .bank_req_o(breq[0]), .bank_resp_i(bresp[0]),
    .bank_off_i(boff[0]), .protocol_err_o(perr[0]));

  obi_bank_demux #(.NUM_BANKS(NB), .BANK_ADDR_WIDTH(15), .INTERLEAVED(1), .MAX_OUTSTANDING(2)) dut_il (
    .clk_i(clk), .rst_i(rst), .master_req_i(mreq[1]), .master_resp_o(mresp[1]),
    .master_err_o(merr[1]), .bank_req_o(breq[1]), .bank_resp_i(bresp[1]),
    .bank_off_i(boff[1]), .protocol_err_o(perr[1]));

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency SRAM bank model per DUT and bank.
  always @(posedge clk) begin : bank_model
    logic [63:0] k;
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < NB; b++) begin
        brv[d][b] <= breq[d][b].req;
        if (breq[d][b].req) begin
          k = (64'(d) << 40) | (64'(b) << 32) | 64'(breq[d][b].addr);
          if (breq[d][b].we) begin
            bmem[k] = breq[d][b].wdata;
            brd[d][b] <= 32'd0;
          end else begin
            brd[d][b] <= bmem.exists(k) ? bmem[k] : 32'd0;
          end
        end
      end
  end

  always_comb begin
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < NB; b++) begin
        bresp[d][b].gnt    = breq[d][b].req;
        bresp[d][b].rvalid = brv[d][b] | inj[d][b];
        bresp[d][b].rdata  = brd[d][b];
      end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every master rvalid must match the oldest expectation.
  always @(negedge clk) begin : monitor
    sb_t e;
    for (int d = 0; d < 2; d++) begin
      if (mresp[d].rvalid === 1'b1) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL unexpected_rvalid dut%0d: got rvalid=1 want none (cycle %0d)", d, cyc);
        end else begin
          if (d == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("rdata dut%0d", d), mresp[d].rdata, e.rdata);
          chk($sformatf("err dut%0d", d), 32'(merr[d]), 32'(e.err));
          chk($sformatf("latency dut%0d", d), cyc, e.cyc);
        end
      end
    end
  end

  // Drive one request just after a posedge; check grant and bank routing.
  task automatic issue(input vec_t v);
    sb_t e;
    mreq[v.d] = '{req: 1'b1, we: v.we, be: 4'hF, addr: v.addr, wdata: v.wdata};
    boff[v.d] = v.off;
    @(negedge clk);
    chk($sformatf("gnt %h", v.addr), 32'(mresp[v.d].gnt), 32'd1);
    for (int b = 0; b < NB; b++)
      chk($sformatf("bank%0d_req %h", b, v.addr), 32'(breq[v.d][b].req), 32'(!v.err && b == v.bank));
    if (!v.err) chk($sformatf("bank_addr %h", v.addr), breq[v.d][v.bank].addr, v.baddr);
    e = '{rdata: v.rdata, err: v.err, cyc: cyc + 1};
    if (v.d == 0) q0.push_back(e);
    else          q1.push_back(e);
    @(posedge clk);
    #1;
    mreq[v.d].req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drain", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      mreq[d] = '0;
      boff[d] = '0;
      inj[d]  = '0;
    end
    //     d we addr          wdata         off  err bank baddr         rdata
    tbl.push_back('{0, 1, 32'h0000_8004, 32'hDEAD_BEEF, 2'b00, 0, 1, 32'h0000_8004, 32'h0});
    tbl.push_back('{0, 0, 32'h0000_8004, 32'h0,         2'b00, 0, 1, 32'h0000_8004, 32'hDEAD_BEEF});
    tbl.push_back('{0, 1, 32'h0000_0000, 32'h1111_0000, 2'b00, 0, 0, 32'h0000_0000, 32'h0});
    tbl.push_back('{0, 1, 32'h0000_8000, 32'h2222_8000, 2'b00, 0, 1, 32'h0000_8000, 32'h0});
    tbl.push_back('{0, 0, 32'h0000_0000, 32'h0,         2'b00, 0, 0, 32'h0000_0000, 32'h1111_0000});
    tbl.push_back('{0, 0, 32'h0000_8000, 32'h0,         2'b00, 0, 1, 32'h0000_8000, 32'h2222_8000});
    tbl.push_back('{0, 0, 32'h0001_0000, 32'h0,         2'b00, 1, 0, 32'h0,         32'h0});
    tbl.push_back('{0, 0, 32'h0000_8000, 32'h0,         2'b10, 1, 0, 32'h0,         32'h0});
    tbl.push_back('{0, 0, 32'h0000_0000, 32'h0,         2'b10, 0, 0, 32'h0000_0000, 32'h1111_0000});
    tbl.push_back('{0, 0, 32'h8000_0000, 32'h0,         2'b00, 1, 0, 32'h0,         32'h0});
    tbl.push_back('{0, 0, 32'h0000_7FFC, 32'h0,         2'b01, 1, 0, 32'h0,         32'h0});
    tbl.push_back('{0, 0, 32'h0000_FFFC, 32'h0,         2'b01, 0, 1, 32'h0000_FFFC, 32'h0});
    tbl.push_back('{1, 1, 32'h0000_0004, 32'hCAFE_0004, 2'b00, 0, 1, 32'h0000_0000, 32'h0});
    tbl.push_back('{1, 1, 32'h0000_0008, 32'hCAFE_0008, 2'b00, 0, 0, 32'h0000_0004, 32'h0});
    tbl.push_back('{1, 0, 32'h0000_0004, 32'h0,         2'b00, 0, 1, 32'h0000_0000, 32'hCAFE_0004});
    tbl.push_back('{1, 0, 32'h0000_0008, 32'h0,         2'b00, 0, 0, 32'h0000_0004, 32'hCAFE_0008});
    tbl.push_back('{1, 0, 32'h0000_FFFC, 32'h0,         2'b00, 0, 1, 32'h0000_7FFC, 32'h0});
    tbl.push_back('{1, 0, 32'h0001_0000, 32'h0,         2'b00, 1, 0, 32'h0,         32'h0});
    tbl.push_back('{1, 0, 32'h0000_000C, 32'h0,         2'b10, 1, 0, 32'h0,         32'h0});

    // Reset state, with a request held to show the grant is suppressed.
    mreq[0] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h0, wdata: 32'h0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(mresp[0].gnt), 32'd0);
    chk("rst_bank0_req", 32'(breq[0][0].req), 32'd0);
    chk("rst_rvalid", 32'(mresp[0].rvalid), 32'd0);
    chk("rst_err", 32'(merr[0]), 32'd0);
    chk("rst_perr", 32'(perr[0]), 32'd0);
    @(posedge clk);
    #1;
    mreq[0].req = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back table vectors.
    foreach (tbl[i]) issue(tbl[i]);
    drain();
    chk("perr_after_table dut0", 32'(perr[0]), 32'd0);
    chk("perr_after_table dut1", 32'(perr[1]), 32'd0);

    // Reset while one read is outstanding.
    mreq[0] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'h0000_8004, wdata: 32'h0};
    boff[0] = 2'b00;
    @(negedge clk);
    chk("pre_rst_gnt", 32'(mresp[0].gnt), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_rvalid", 32'(mresp[0].rvalid), 32'd0);
    chk("mid_rst_gnt", 32'(mresp[0].gnt), 32'd0);
    chk("mid_rst_bank1_req", 32'(breq[0][1].req), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mreq[0].req = 1'b0;
    inj[0] = 2'b01;
    @(posedge clk);
    #1;
    inj[0] = 2'b00;
    @(negedge clk);
    chk("post_rst_drop_perr", 32'(perr[0]), 32'd0);
    chk("post_rst_rvalid", 32'(mresp[0].rvalid), 32'd0);
    @(posedge clk);
    #1;
    // Bank0 read: a stale bank1 head entry would turn this into a stray.
    issue('{0, 0, 32'h0000_0000, 32'h0, 2'b00, 0, 0, 32'h0000_0000, 32'h1111_0000});
    drain();
    chk("post_rst_perr", 32'(perr[0]), 32'd0);

    // Stray bank rvalid with the FIFO empty.
    inj[0] = 2'b01;
    @(posedge clk);
    #1;
    inj[0] = 2'b00;
    @(negedge clk);
    chk("stray_perr_set", 32'(perr[0]), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("stray_perr_sticky", 32'(perr[0]), 32'd1);
    chk("stray_perr_other_dut", 32'(perr[1]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("perr_cleared_by_rst", 32'(perr[0]), 32'd0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
